// File: rtl/control_unit_p.sv
// Multi-cycle instruction sequencer: fetches NFETCH flash words per instruction,
// then decodes and drives the register file, ALU, SRAM, PC and GPIO in EXEC/MEM_WAIT.
module control_unit_p #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int PC_W   = 12
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_W-1:0]     i_flash_data,
  input  logic                  i_flash_valid,
  input  logic [DATA_W-1:0]     i_sram_read_data,
  input  logic [DATA_W-1:0]     i_alu_result,
  input  logic                  i_carry_out,
  input  logic                  i_a_greater,
  input  logic                  i_a_equal,
  input  logic [DATA_W-1:0]     i_in_gpio,
  input  logic [DATA_W-1:0]     i_reg_read_data_a,
  input  logic [DATA_W-1:0]     i_reg_read_data_b,
  output logic [2:0]            o_alu_opcode,
  output logic [DATA_W-1:0]     o_alu_a,
  output logic [DATA_W-1:0]     o_alu_b,
  output logic                  o_sram_write_en,
  output logic [2*REG_AW-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]     o_sram_write_data,
  output logic                  o_pc_inc,
  output logic                  o_pc_load,
  output logic [PC_W-1:0]       o_pc_next,
  output logic                  o_reg_write_en,
  output logic [REG_AW-1:0]     o_reg_write_addr,
  output logic [REG_AW-1:0]     o_reg_read_addr_a,
  output logic [REG_AW-1:0]     o_reg_read_addr_b,
  output logic [DATA_W-1:0]     o_reg_write_data,
  output logic [DATA_W-1:0]     o_out_gpio,
  output logic [2:0]            o_flags
);

  localparam int INSTR_W = 4 + 3*REG_AW;
  localparam int NFETCH  = INSTR_W / DATA_W;
  localparam int K_W     = (NFETCH > 1) ? $clog2(NFETCH) : 1;
  localparam int TGT_W   = 3*REG_AW;

  typedef enum logic [1:0] {
    S_FETCH    = 2'b00,
    S_EXEC     = 2'b01,
    S_MEM_WAIT = 2'b10
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [K_W-1:0]       r_k;
  logic [K_W-1:0]       w_k_nxt;
  logic [INSTR_W-1:0]   r_instr;
  logic [INSTR_W-1:0]   w_instr_nxt;
  logic [2:0]           r_flags;
  logic [2:0]           w_flags_nxt;
  logic [DATA_W-1:0]    r_out_gpio;
  logic [DATA_W-1:0]    w_out_gpio_nxt;

  logic [3:0]           w_opcode;
  logic [REG_AW-1:0]    w_dst;
  logic [REG_AW-1:0]    w_a;
  logic [REG_AW-1:0]    w_b;
  logic [2*REG_AW-1:0]  w_mem_addr;
  logic [TGT_W-1:0]     w_target;
  logic [PC_W-1:0]      w_pc_target;

  assign w_opcode   = r_instr[INSTR_W-1 -: 4];
  assign w_dst      = r_instr[3*REG_AW-1 -: REG_AW];
  assign w_a        = r_instr[2*REG_AW-1 -: REG_AW];
  assign w_b        = r_instr[REG_AW-1:0];
  assign w_mem_addr = {w_a, w_b};
  assign w_target   = r_instr[TGT_W-1:0];

  // Jump target is zero-extended or truncated (LSBs kept) to the PC width
  generate
    if (PC_W > TGT_W) begin : g_pc_ext
      assign w_pc_target = {{(PC_W-TGT_W){1'b0}}, w_target};
    end else begin : g_pc_trunc
      assign w_pc_target = w_target[PC_W-1:0];
    end
  endgenerate

  assign o_flags    = r_flags;
  assign o_out_gpio = r_out_gpio;

  // State, fetch counter, instruction, flags and GPIO registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_FETCH;
      r_k        <= '0;
      r_instr    <= '0;
      r_flags    <= 3'b000;
      r_out_gpio <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_k        <= w_k_nxt;
      r_instr    <= w_instr_nxt;
      r_flags    <= w_flags_nxt;
      r_out_gpio <= w_out_gpio_nxt;
    end
  end

  // Next-state and decode; reset forces every strobe and data output to zero
  always_comb begin
    w_state_nxt       = r_state;
    w_k_nxt           = r_k;
    w_instr_nxt       = r_instr;
    w_flags_nxt       = r_flags;
    w_out_gpio_nxt    = r_out_gpio;
    o_alu_opcode      = 3'b000;
    o_alu_a           = '0;
    o_alu_b           = '0;
    o_sram_write_en   = 1'b0;
    o_sram_addr       = '0;
    o_sram_write_data = '0;
    o_pc_inc          = 1'b0;
    o_pc_load         = 1'b0;
    o_pc_next         = '0;
    o_reg_write_en    = 1'b0;
    o_reg_write_addr  = '0;
    o_reg_read_addr_a = '0;
    o_reg_read_addr_b = '0;
    o_reg_write_data  = '0;

    if (i_rst) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_flash_valid) begin
            o_pc_inc = 1'b1;
            // word k lands MS-first: k=0 fills the top slice
            for (int w = 0; w < NFETCH; w++) begin
              if (r_k == K_W'(NFETCH-1-w)) begin
                w_instr_nxt[w*DATA_W +: DATA_W] = i_flash_data;
              end else begin
                w_instr_nxt[w*DATA_W +: DATA_W] = r_instr[w*DATA_W +: DATA_W];
              end
            end
            if (r_k == K_W'(NFETCH-1)) begin
              w_k_nxt     = '0;
              w_state_nxt = S_EXEC;
            end else begin
              w_k_nxt     = r_k + K_W'(1);
              w_state_nxt = S_FETCH;
            end
          end else begin
            w_state_nxt = S_FETCH;
          end
        end

        S_EXEC: begin
          w_state_nxt = S_FETCH;
          case (w_opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              o_reg_read_addr_a = w_a;
              o_reg_read_addr_b = w_b;
              o_alu_a           = i_reg_read_data_a;
              o_alu_b           = i_reg_read_data_b;
              o_alu_opcode      = w_opcode[2:0];
              o_reg_write_en    = 1'b1;
              o_reg_write_addr  = w_dst;
              o_reg_write_data  = i_alu_result;
              w_flags_nxt       = {i_carry_out, i_a_greater, i_a_equal};
            end
            4'h8: begin
              o_sram_addr = w_mem_addr;
              w_state_nxt = S_MEM_WAIT;
            end
            4'h9: begin
              o_reg_read_addr_a = w_dst;
              o_sram_addr       = w_mem_addr;
              o_sram_write_data = i_reg_read_data_a;
              o_sram_write_en   = 1'b1;
            end
            4'hA: begin
              o_pc_load = 1'b1;
              o_pc_next = w_pc_target;
            end
            4'hB: begin
              if (r_flags[0]) begin
                o_pc_load = 1'b1;
                o_pc_next = w_pc_target;
              end else begin
                o_pc_load = 1'b0;
              end
            end
            4'hC: begin
              if (r_flags[1]) begin
                o_pc_load = 1'b1;
                o_pc_next = w_pc_target;
              end else begin
                o_pc_load = 1'b0;
              end
            end
            4'hD: begin
              if (r_flags[2]) begin
                o_pc_load = 1'b1;
                o_pc_next = w_pc_target;
              end else begin
                o_pc_load = 1'b0;
              end
            end
            4'hE: begin
              o_reg_write_en   = 1'b1;
              o_reg_write_addr = w_dst;
              o_reg_write_data = i_in_gpio;
            end
            4'hF: begin
              o_reg_read_addr_a = w_dst;
              w_out_gpio_nxt    = i_reg_read_data_a;
            end
            default: begin
              w_state_nxt = S_FETCH;
            end
          endcase
        end

        S_MEM_WAIT: begin
          o_sram_addr      = w_mem_addr;
          o_reg_write_en   = 1'b1;
          o_reg_write_addr = w_dst;
          o_reg_write_data = i_sram_read_data;
          w_state_nxt      = S_FETCH;
        end

        default: begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit_p.sv
// Randomized and directed bench for control_unit_p (default parameters), checked
// cycle by cycle against a behavioural model of the instruction sequence.
module tb_control_unit_p;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  flash_data;
  logic        flash_valid;
  logic [7:0]  sram_read_data;
  logic [7:0]  alu_result;
  logic        carry_out, a_greater, a_equal;
  logic [7:0]  in_gpio, rd_a, rd_b;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b;
  logic        sram_we;
  logic [7:0]  sram_addr;
  logic [7:0]  sram_wdata;
  logic        pc_inc, pc_load;
  logic [11:0] pc_next;
  logic        reg_we;
  logic [3:0]  reg_wa, reg_ra_a, reg_ra_b;
  logic [7:0]  reg_wd;
  logic [7:0]  out_gpio;
  logic [2:0]  flags;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Model: words collected so far, phase 0=fetching 1=execute 2=load data cycle
  int          m_words;
  int          m_phase;
  logic [15:0] m_instr;
  logic [2:0]  m_flags;
  logic [7:0]  m_gpio;

  always #5 clk = ~clk;

  control_unit_p dut (
    .i_clk(clk), .i_rst(rst),
    .i_flash_data(flash_data), .i_flash_valid(flash_valid),
    .i_sram_read_data(sram_read_data), .i_alu_result(alu_result),
    .i_carry_out(carry_out), .i_a_greater(a_greater), .i_a_equal(a_equal),
    .i_in_gpio(in_gpio), .i_reg_read_data_a(rd_a), .i_reg_read_data_b(rd_b),
    .o_alu_opcode(alu_opcode), .o_alu_a(alu_a), .o_alu_b(alu_b),
    .o_sram_write_en(sram_we), .o_sram_addr(sram_addr), .o_sram_write_data(sram_wdata),
    .o_pc_inc(pc_inc), .o_pc_load(pc_load), .o_pc_next(pc_next),
    .o_reg_write_en(reg_we), .o_reg_write_addr(reg_wa),
    .o_reg_read_addr_a(reg_ra_a), .o_reg_read_addr_b(reg_ra_b),
    .o_reg_write_data(reg_wd), .o_out_gpio(out_gpio), .o_flags(flags)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: check outputs for the current inputs, then advance the model at the edge
  task automatic tick();
    int op, dst, a, b;
    logic        e_inc, e_load, e_swe, e_rwe;
    logic [11:0] e_pcn;
    logic [7:0]  e_sa, e_swd, e_wd, e_aa, e_ab;
    logic [3:0]  e_wa, e_rda, e_rdb;
    logic [2:0]  e_aop;
    op  = int'(m_instr) / 4096;
    dst = (int'(m_instr) / 256) % 16;
    a   = (int'(m_instr) / 16) % 16;
    b   = int'(m_instr) % 16;
    e_inc = 1'b0; e_load = 1'b0; e_swe = 1'b0; e_rwe = 1'b0; e_pcn = 12'h000;
    e_sa = 8'h00; e_swd = 8'h00; e_wd = 8'h00; e_aa = 8'h00; e_ab = 8'h00;
    e_wa = 4'h0; e_rda = 4'h0; e_rdb = 4'h0; e_aop = 3'b000;
    #1;
    if (!rst) begin
      if (m_phase == 0) begin
        e_inc = flash_valid;
      end else if (m_phase == 2) begin
        e_sa = 8'(a * 16 + b); e_rwe = 1'b1; e_wa = 4'(dst); e_wd = sram_read_data;
      end else if (op < 8) begin
        e_rda = 4'(a); e_rdb = 4'(b); e_aa = rd_a; e_ab = rd_b; e_aop = 3'(op);
        e_rwe = 1'b1; e_wa = 4'(dst); e_wd = alu_result;
      end else if (op == 8) begin
        e_sa = 8'(a * 16 + b);
      end else if (op == 9) begin
        e_rda = 4'(dst); e_sa = 8'(a * 16 + b); e_swd = rd_a; e_swe = 1'b1;
      end else if (op == 14) begin
        e_rwe = 1'b1; e_wa = 4'(dst); e_wd = in_gpio;
      end else if (op == 15) begin
        e_rda = 4'(dst);
      end else if (op == 10 || (op == 11 && m_flags[0]) || (op == 12 && m_flags[1])
                   || (op == 13 && m_flags[2])) begin
        e_load = 1'b1; e_pcn = m_instr[11:0];
      end
    end
    check_eq("pc_inc", 32'(pc_inc), 32'(e_inc));
    check_eq("pc_load", 32'(pc_load), 32'(e_load));
    check_eq("pc_next", 32'(pc_next), 32'(e_pcn));
    check_eq("inc_load_excl", 32'(pc_inc & pc_load), 32'd0);
    check_eq("reg_we", 32'(reg_we), 32'(e_rwe));
    check_eq("reg_wa", 32'(reg_wa), 32'(e_wa));
    check_eq("reg_wd", 32'(reg_wd), 32'(e_wd));
    check_eq("reg_ra_a", 32'(reg_ra_a), 32'(e_rda));
    check_eq("reg_ra_b", 32'(reg_ra_b), 32'(e_rdb));
    check_eq("alu_op", 32'(alu_opcode), 32'(e_aop));
    check_eq("alu_a", 32'(alu_a), 32'(e_aa));
    check_eq("alu_b", 32'(alu_b), 32'(e_ab));
    check_eq("sram_we", 32'(sram_we), 32'(e_swe));
    check_eq("sram_addr", 32'(sram_addr), 32'(e_sa));
    check_eq("sram_wdata", 32'(sram_wdata), 32'(e_swd));
    check_eq("flags", 32'(flags), 32'(m_flags));
    check_eq("out_gpio", 32'(out_gpio), 32'(m_gpio));
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_words = 0; m_phase = 0; m_instr = 16'h0000; m_flags = 3'b000; m_gpio = 8'h00;
    end else begin
      case (m_phase)
        0: begin
          if (flash_valid) begin
            m_instr = {m_instr[7:0], flash_data};
            m_words++;
            if (m_words == 2) begin
              m_words = 0;
              m_phase = 1;
            end
          end
        end
        1: begin
          if (op < 8) m_flags = {carry_out, a_greater, a_equal};
          if (op == 15) m_gpio = rd_a;
          m_phase = (op == 8) ? 2 : 0;
        end
        default: m_phase = 0;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] w);
    flash_valid = 1'b1;
    flash_data  = w[15:8];
    tick();
    flash_data  = w[7:0];
    tick();
    flash_valid = 1'b0;
  endtask

  task automatic run_instr(input logic [15:0] w);
    feed(w);
    tick();
    if (w[15:12] == 4'h8) tick();
  endtask

  initial begin
    rst = 1'b1; flash_data = 8'h00; flash_valid = 1'b0; sram_read_data = 8'h00;
    alu_result = 8'h00; carry_out = 1'b0; a_greater = 1'b0; a_equal = 1'b0;
    in_gpio = 8'h00; rd_a = 8'h00; rd_b = 8'h00;
    m_words = 0; m_phase = 0; m_instr = 16'h0000; m_flags = 3'b000; m_gpio = 8'h00;
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;

    // ADD r2 = r3 op r4 with continuous valid words
    alu_result = 8'h77; rd_a = 8'h31; rd_b = 8'h42;
    run_instr(16'h1234);
    // stall three cycles between the two words
    flash_valid = 1'b1; flash_data = 8'h12; tick();
    flash_valid = 1'b0;
    repeat (3) tick();
    flash_valid = 1'b1; flash_data = 8'h34; tick();
    flash_valid = 1'b0; tick();
    // LOAD r5 <- [0xA7]
    sram_read_data = 8'h5C;
    run_instr(16'h85A7);
    // BEQ taken and not taken
    a_equal = 1'b1; run_instr(16'h1234); a_equal = 1'b0;
    run_instr(16'hB123);
    run_instr(16'h1234);
    run_instr(16'hB123);
    // OUT then three unrelated instructions
    rd_a = 8'hA5; run_instr(16'hF300); rd_a = 8'h11;
    run_instr(16'h1234); run_instr(16'hE100); run_instr(16'hA055);
    // reset during MEM_WAIT of a LOAD, then a STORE from scratch
    carry_out = 1'b1; run_instr(16'h2345); carry_out = 1'b0;
    feed(16'h85A7); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    run_instr(16'h9312);
    run_instr(16'hD0FF);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst            = ($urandom_range(0, 59) == 0);
      flash_valid    = ($urandom_range(0, 3) != 0);
      flash_data     = 8'($urandom);
      sram_read_data = 8'($urandom);
      alu_result     = 8'($urandom);
      carry_out      = 1'($urandom);
      a_greater      = 1'($urandom);
      a_equal        = 1'($urandom);
      in_gpio        = 8'($urandom);
      rd_a           = 8'($urandom);
      rd_b           = 8'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit_p.md
CONTROL_UNIT_P -- requirements
Module: control_unit_p

Interface
REQ-001 Parameter DATA_W, default 8, datapath/flash/SRAM/GPIO word width.
REQ-002 Parameter REG_AW, default 4, register-file address width; instruction = {opcode[3:0], dst, a, b}, INSTR_W = 4+3*REG_AW (default 16).
REQ-003 Parameter PC_W, default 12, program-counter width.
REQ-004 INSTR_W SHALL be an integer multiple of DATA_W; NFETCH = INSTR_W/DATA_W (default 2) flash words per instruction.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 flash_data  in  DATA_W  instruction word at current PC; flash_valid  in  1  flash_data valid this cycle.
REQ-008 sram_read_data  in  DATA_W  SRAM read data, valid one cycle after sram_addr is presented.
REQ-009 alu_result  in  DATA_W; carry_out, a_greater, a_equal  in  1 each  ALU result and status.
REQ-010 in_gpio  in  DATA_W; reg_read_data_a, reg_read_data_b  in  DATA_W  register-file read ports.
REQ-011 alu_opcode  out  3; alu_a, alu_b  out  DATA_W.
REQ-012 sram_write_en  out  1; sram_addr  out  2*REG_AW; sram_write_data  out  DATA_W.
REQ-013 pc_inc  out  1; pc_load  out  1; pc_next  out  PC_W.
REQ-014 reg_write_en  out  1; reg_write_addr, reg_read_addr_a, reg_read_addr_b  out  REG_AW; reg_write_data  out  DATA_W.
REQ-015 out_gpio  out  DATA_W  registered output port; flags  out  3  {carry, greater, equal} registered status.

Function
REQ-016 States: FETCH, EXEC, MEM_WAIT; 2-bit encoding; any unused encoding SHALL return to FETCH next cycle.
REQ-017 FETCH: fetch counter k (0..NFETCH-1); on flash_valid=1, capture flash_data as the k-th word (most-significant first), assert pc_inc combinationally that cycle, increment k; on capture with k=NFETCH-1, clear k, go EXEC.
REQ-018 FETCH with flash_valid=0: hold k and partial instruction, pc_inc=0, wait indefinitely.
REQ-019 Opcode 0-7 (ALU), EXEC: read_addr_a=a, read_addr_b=b, alu_a/alu_b = read data, alu_opcode=opcode[2:0], reg_write_en=1, write_addr=dst, write_data=alu_result; flags <= {carry_out,a_greater,a_equal} at cycle end; go FETCH.
REQ-020 Opcode 8 (LOAD): EXEC drives sram_addr={a,b}, goes MEM_WAIT; MEM_WAIT holds sram_addr, reg_write_en=1, write_addr=dst, write_data=sram_read_data; go FETCH.
REQ-021 Opcode 9 (STORE), EXEC: read_addr_a=dst, sram_addr={a,b}, sram_write_data=reg_read_data_a, sram_write_en=1 one cycle.
REQ-022 Opcode A (JMP): pc_load=1, pc_next={dst,a,b} zero-extended or truncated (LSBs kept) to PC_W.
REQ-023 Opcodes B/C/D (BEQ/BGT/BC): pc_load=1 with pc_next per REQ-022 only if flags equal/greater/carry bit = 1; else pc_load=0; flags written only by ALU ops, so they reflect the most recent ALU instruction.
REQ-024 Opcode E (IN): reg_write_en=1, write_addr=dst, write_data=in_gpio.
REQ-025 Opcode F (OUT): read_addr_a=dst; out_gpio <= reg_read_data_a at cycle end; out_gpio holds until next OUT or reset.
REQ-026 Outside the cases above, reg_write_en, sram_write_en, pc_load, pc_inc = 0 and data/addr outputs = 0; every instruction except LOAD takes exactly NFETCH fetch cycles + 1 EXEC cycle.
REQ-027 pc_inc and pc_load SHALL never be asserted in the same cycle.

Reset
REQ-028 rst=1 at a clock edge: state=FETCH, k=0, instruction=0, flags=0, out_gpio=0; all strobes 0 while rst=1, including mid-fetch, in EXEC or MEM_WAIT (in-flight write suppressed).
REQ-029 After rst deasserts, the first captured word is the MS word of a new instruction.

Verification
REQ-030 Defaults, flash_valid=1, words 0x12,0x34 (ADD r2=r3 op r4): pc_inc on fetch cycles 1-2, EXEC cycle 3: alu_opcode=1, read addrs 3/4, reg_write_en=1, write_addr=2.
REQ-031 flash_valid low 3 cycles between words -> no pc_inc during stall, instruction still decoded correctly, EXEC 1 cycle after second valid word.
REQ-032 LOAD 0x85A7 with sram_read_data=0x5C -> sram_addr=0xA7 in EXEC and MEM_WAIT, reg_write_en=1 addr 5 data 0x5C in MEM_WAIT only.
REQ-033 ALU with a_equal=1 then BEQ 0xB123 -> pc_load=1, pc_next=0x123; ALU with a_equal=0 then same BEQ -> pc_load=0.
REQ-034 OUT 0xF300, reg_read_data_a=0xA5 -> out_gpio=0xA5 after EXEC, held across 3 subsequent instructions.
REQ-035 rst=1 during MEM_WAIT of a LOAD -> no reg_write_en, flags=0, out_gpio=0, fetch restarts at word 0.
